// File: rtl/intr_pkg.sv
// Shared types and helpers for the multi-source interrupt controller.
package intr_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      PUSH,
      LOAD,
      SERVICE
   } intr_state_t;

   localparam int PC_W_DFLT   = 32;
   localparam int DATA_W_DFLT = 16;
   localparam int WORDS       = PC_W_DFLT / DATA_W_DFLT;

   // Each vector slot is one full PC wide, i.e. `words` stack words apart.
   function automatic int unsigned vec_addr(input int unsigned base,
                                            input int unsigned words,
                                            input int unsigned id);
      return base + id * words;
   endfunction

endpackage

// File: rtl/intr_controller_if.sv
// Pipeline-side bundle: drain status, PC/flags to save, stack push port, vector load.
interface intr_controller_if
   import intr_pkg::*;
#(
   parameter int PC_W   = PC_W_DFLT,
   parameter int DATA_W = DATA_W_DFLT,
   parameter int FLAG_W = 3
);
   logic              pipe_empty;
   logic [PC_W-1:0]   pc_in;
   logic [FLAG_W-1:0] flags_in;
   logic              push_valid;
   logic [DATA_W-1:0] push_data;
   logic              push_ready;
   logic              fetch_stall;
   logic              pc_load;
   logic [PC_W-1:0]   pc_load_value;
   logic              rti_done;

   modport master (
      input  pipe_empty, pc_in, flags_in, push_ready, rti_done,
      output push_valid, push_data, fetch_stall, pc_load, pc_load_value
   );

   modport slave (
      output pipe_empty, pc_in, flags_in, push_ready, rti_done,
      input  push_valid, push_data, fetch_stall, pc_load, pc_load_value
   );
endinterface

// File: rtl/prio_encoder.sv
// Fixed-priority encoder: lowest set request index wins.
module prio_encoder #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req,
   output logic            valid,
   output logic [ID_W-1:0] id
);

   always_comb begin
      valid = |req;
      id    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) id = ID_W'(i);
      end
   end

endmodule

// File: rtl/intr_controller.sv
// Multi-source interrupt controller: latch, mask, prioritise, then sequence
// the entry (stall fetch, drain, push PC and flags, load vector) until RTI.
//
// state   | meaning
// IDLE    | selecting; accepts the lowest eligible source
// DRAIN   | fetch stalled, waiting for pipe_empty
// PUSH    | pushing PC words MSW first, then zero-extended flags
// LOAD    | one-cycle vector load strobe, fetch released
// SERVICE | handler running, waiting for rti_done
module intr_controller
   import intr_pkg::*;
#(
   parameter int          N_SRC     = 4,
   parameter int          PC_W      = PC_W_DFLT,
   parameter int          DATA_W    = DATA_W_DFLT,
   parameter int          FLAG_W    = 3,
   parameter int unsigned VEC_BASE  = 0,
   parameter bit          EDGE_MODE = 1'b1,
   localparam int         ID_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_SRC-1:0]  irq,
   input  logic              mask_we,
   input  logic [N_SRC-1:0]  mask_wdata,
   intr_controller_if.master cpu,
   output logic              in_service,
   output logic [ID_W-1:0]   active_id,
   output logic [N_SRC-1:0]  pending
);

   localparam int N_WORDS = PC_W / DATA_W;
   localparam int CNT_W   = $clog2(N_WORDS + 1);

   intr_state_t      state, state_nxt;
   logic [N_SRC-1:0] mask, irq_q, req_set, req_clr, eligible;
   logic             sel_valid, accept, beat_done;
   logic [ID_W-1:0]  sel_id, id_q;
   logic [PC_W-1:0]  pc_sr;
   logic [FLAG_W-1:0] flags_q;
   logic [CNT_W-1:0] beat_cnt;

   assign eligible = pending & mask;

   prio_encoder #(.N(N_SRC), .ID_W(ID_W)) u_prio (
      .req   (eligible),
      .valid (sel_valid),
      .id    (sel_id)
   );

   assign accept    = (state == IDLE) && sel_valid;
   assign beat_done = (state == PUSH) && cpu.push_ready;
   assign req_set   = EDGE_MODE ? (irq & ~irq_q) : irq;
   assign req_clr   = accept ? (N_SRC'(1) << sel_id) : '0;
   assign active_id = id_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Set wins over clear so an edge coinciding with acceptance is not lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mask     <= '1;
         irq_q    <= '0;
         pending  <= '0;
         id_q     <= '0;
         pc_sr    <= '0;
         flags_q  <= '0;
         beat_cnt <= '0;
      end else begin
         irq_q   <= irq;
         pending <= (pending & ~req_clr) | req_set;
         if (mask_we) mask <= mask_wdata;
         if (accept) begin
            id_q    <= sel_id;
            pc_sr   <= cpu.pc_in;
            flags_q <= cpu.flags_in;
         end
         // beat_cnt counts remaining PC words; zero means the flags beat.
         if (state == DRAIN) begin
            beat_cnt <= CNT_W'(N_WORDS);
         end else if (beat_done) begin
            beat_cnt <= beat_cnt - 1'b1;
            pc_sr    <= pc_sr << DATA_W;
         end
      end
   end

   always_comb begin
      state_nxt         = state;
      cpu.push_valid    = 1'b0;
      cpu.push_data     = '0;
      cpu.fetch_stall   = 1'b0;
      cpu.pc_load       = 1'b0;
      cpu.pc_load_value = '0;
      in_service        = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = DRAIN;
         end
         DRAIN: begin
            cpu.fetch_stall = 1'b1;
            if (cpu.pipe_empty) state_nxt = PUSH;
         end
         PUSH: begin
            cpu.fetch_stall = 1'b1;
            cpu.push_valid  = 1'b1;
            cpu.push_data   = (beat_cnt == '0) ? DATA_W'(flags_q) : pc_sr[PC_W-1 -: DATA_W];
            if (beat_done && beat_cnt == '0) state_nxt = LOAD;
         end
         LOAD: begin
            cpu.pc_load       = 1'b1;
            cpu.pc_load_value = PC_W'(vec_addr(VEC_BASE, N_WORDS, 32'(id_q)));
            state_nxt         = SERVICE;
         end
         SERVICE: begin
            in_service = 1'b1;
            if (cpu.rti_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_intr_controller.sv
// Bench for intr_controller: directed entry scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_intr_controller;
   import intr_pkg::*;

   localparam int N = 4;
   localparam int PH_IDLE = 0, PH_DRAIN = 1, PH_PUSH = 2, PH_LOAD = 3, PH_SVC = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] irq, mask_wdata, irq_l;
   logic         mask_we;
   logic         in_service, in_service_l;
   logic [1:0]   active_id, active_id_l;
   logic [N-1:0] pending, pending_l;

   intr_controller_if bus ();
   intr_controller_if bus_l ();

   intr_controller #(.N_SRC(N), .EDGE_MODE(1'b1)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .irq        (irq),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .cpu        (bus),
      .in_service (in_service),
      .active_id  (active_id),
      .pending    (pending)
   );

   intr_controller #(.N_SRC(N), .EDGE_MODE(1'b0)) u_dut_lvl (
      .clk        (clk),
      .rst        (rst),
      .irq        (irq_l),
      .mask_we    (1'b0),
      .mask_wdata ({N{1'b1}}),
      .cpu        (bus_l),
      .in_service (in_service_l),
      .active_id  (active_id_l),
      .pending    (pending_l)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0, cyc = 0;
   int c0, lc, pi;
   int load_cnt = 0, last_load_cyc = 0;
   logic [31:0] last_load_val;
   logic [15:0] obs_push[$];
   logic [4:0]  rdy_pat;

   int          m_ph, m_id;
   logic [N-1:0] m_pend, m_mask, m_prev;
   logic [15:0] m_words[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_ph   = PH_IDLE;
      m_id   = 0;
      m_pend = '0;
      m_mask = '1;
      m_prev = '0;
      m_words.delete();
   endtask

   // Advances the model by one clock using the inputs held during that cycle.
   task automatic model_step();
      logic [N-1:0] set_v, clr_v, elig;
      logic [15:0]  w;
      if (!rst) begin
         model_reset();
         return;
      end
      set_v = irq & ~m_prev;
      clr_v = '0;
      case (m_ph)
         PH_IDLE: begin
            elig = m_pend & m_mask;
            if (elig != 0) begin
               for (int i = 0; i < N; i++) begin
                  if (elig[i]) begin m_id = i; break; end
               end
               clr_v[m_id] = 1'b1;
               m_words.delete();
               m_words.push_back(bus.pc_in[31:16]);
               m_words.push_back(bus.pc_in[15:0]);
               m_words.push_back({13'b0, bus.flags_in});
               m_ph = PH_DRAIN;
            end
         end
         PH_DRAIN: if (bus.pipe_empty) m_ph = PH_PUSH;
         PH_PUSH: begin
            if (bus.push_ready) begin
               w = m_words.pop_front();
               if (m_words.size() == 0) m_ph = PH_LOAD;
            end
         end
         PH_LOAD: m_ph = PH_SVC;
         default: if (bus.rti_done) m_ph = PH_IDLE;
      endcase
      m_pend = (m_pend & ~clr_v) | set_v;
      if (mask_we) m_mask = mask_wdata;
      m_prev = irq;
   endtask

   task automatic compare_all();
      bit exp_push;
      exp_push = (m_ph == PH_PUSH);
      chk("fetch_stall", 64'(bus.fetch_stall), 64'(m_ph == PH_DRAIN || m_ph == PH_PUSH));
      chk("push_valid", 64'(bus.push_valid), 64'(exp_push));
      chk("push_data", 64'(bus.push_data), exp_push ? 64'(m_words[0]) : 64'(0));
      chk("pc_load", 64'(bus.pc_load), 64'(m_ph == PH_LOAD));
      chk("pc_load_value", 64'(bus.pc_load_value), (m_ph == PH_LOAD) ? 64'(m_id * 2) : 64'(0));
      chk("in_service", 64'(in_service), 64'(m_ph == PH_SVC));
      chk("active_id", 64'(active_id), 64'(m_id));
      chk("pending", 64'(pending), 64'(m_pend));
      if (bus.push_valid && bus.push_ready) obs_push.push_back(bus.push_data);
      if (bus.pc_load) begin
         load_cnt++;
         last_load_cyc = cyc;
         last_load_val = bus.pc_load_value;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
   endtask

   task automatic wait_svc(input string tag);
      for (int i = 0; i < 40 && !in_service; i++) cycle();
      chk({tag, "_svc_reached"}, 64'(in_service), 64'(1));
   endtask

   task automatic finish_svc();
      bus.rti_done = 1'b1;
      cycle();
      bus.rti_done = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      irq = '0; mask_we = 1'b0; mask_wdata = '0;
      bus.pipe_empty = 1'b1; bus.push_ready = 1'b1; bus.rti_done = 1'b0;
      bus.pc_in = '0; bus.flags_in = '0;
      irq_l = '0;
      bus_l.pipe_empty = 1'b1; bus_l.push_ready = 1'b1; bus_l.rti_done = 1'b0;
      bus_l.pc_in = '0; bus_l.flags_in = '0;
      rdy_pat = 5'b10101;
      model_reset();
      #2 rst = 1'b0;
      repeat (3) cycle();
      chk("rst_pending", 64'(pending), 64'(0));
      chk("rst_stall", 64'(bus.fetch_stall), 64'(0));
      chk("rst_active_id", 64'(active_id), 64'(0));
      rst = 1'b1;
      repeat (2) cycle();

      // Single edge on source 2 with a free-flowing pipeline.
      bus.pc_in = 32'h0000_1234; bus.flags_in = 3'b101;
      obs_push.delete(); lc = load_cnt; c0 = cyc;
      irq = 4'b0100; cycle(); irq = '0;
      for (int i = 0; i < 12 && load_cnt == lc; i++) cycle();
      chk("s1_load_seen", 64'(load_cnt - lc), 64'(1));
      chk("s1_latency", 64'(last_load_cyc - c0), 64'(6));
      chk("s1_vector", 64'(last_load_val), 64'(4));
      chk("s1_npush", 64'(obs_push.size()), 64'(WORDS + 1));
      if (obs_push.size() == 3) begin
         chk("s1_word0", 64'(obs_push[0]), 64'h0000);
         chk("s1_word1", 64'(obs_push[1]), 64'h1234);
         chk("s1_word2", 64'(obs_push[2]), 64'h0005);
      end
      wait_svc("s1");
      chk("s1_id", 64'(active_id), 64'(2));
      finish_svc();
      cycle();

      // Two simultaneous requests: lower index first, the other re-enters after RTI.
      irq = 4'b1010; cycle(); irq = '0;
      wait_svc("s2");
      chk("s2_id", 64'(active_id), 64'(1));
      chk("s2_pend", 64'(pending), 64'(4'b1000));
      finish_svc();
      chk("s2_exit", 64'(in_service), 64'(0));
      chk("s2_accept_cycle", 64'(bus.fetch_stall), 64'(0));
      cycle();
      chk("s2_reentry_stall", 64'(bus.fetch_stall), 64'(1));
      chk("s2_reentry_id", 64'(active_id), 64'(3));
      wait_svc("s2b");
      finish_svc();

      // Masked request stays latched and fires two cycles after unmasking.
      mask_we = 1'b1; mask_wdata = 4'b1110; cycle(); mask_we = 1'b0;
      irq = 4'b0001; cycle(); irq = '0;
      repeat (4) cycle();
      chk("s3_pend0", 64'(pending[0]), 64'(1));
      chk("s3_no_entry", 64'(bus.fetch_stall | in_service), 64'(0));
      mask_we = 1'b1; mask_wdata = 4'b1111; cycle(); mask_we = 1'b0;
      chk("s3_w1_stall", 64'(bus.fetch_stall), 64'(0));
      cycle();
      chk("s3_w2_stall", 64'(bus.fetch_stall), 64'(1));
      chk("s3_id", 64'(active_id), 64'(0));
      wait_svc("s3");
      finish_svc();

      // Slow drain and a stuttering push port.
      obs_push.delete(); lc = load_cnt; pi = 0;
      irq = 4'b0010; cycle(); irq = '0;
      bus.pipe_empty = 1'b0; repeat (4) cycle(); bus.pipe_empty = 1'b1;
      chk("s4_drain_hold", 64'(bus.fetch_stall), 64'(1));
      chk("s4_no_push_yet", 64'(bus.push_valid), 64'(0));
      for (int i = 0; i < 20 && load_cnt == lc; i++) begin
         if (bus.push_valid && pi < 5) begin
            bus.push_ready = rdy_pat[pi];
            pi++;
         end else begin
            bus.push_ready = 1'b1;
         end
         cycle();
      end
      bus.push_ready = 1'b1;
      chk("s4_npush", 64'(obs_push.size()), 64'(3));
      chk("s4_ready_beats", 64'(pi), 64'(5));
      chk("s4_load_seen", 64'(load_cnt - lc), 64'(1));
      wait_svc("s4");
      finish_svc();

      // Reset asserted during the second push beat.
      obs_push.delete(); lc = load_cnt;
      irq = 4'b0100; cycle(); irq = '0;
      for (int i = 0; i < 10 && obs_push.size() < 1; i++) cycle();
      chk("s5_in_beat2", 64'(bus.push_valid), 64'(1));
      rst = 1'b0;
      #1;
      chk("s5_async_push_valid", 64'(bus.push_valid), 64'(0));
      chk("s5_async_push_data", 64'(bus.push_data), 64'(0));
      chk("s5_async_stall", 64'(bus.fetch_stall), 64'(0));
      chk("s5_async_pc_load", 64'(bus.pc_load), 64'(0));
      chk("s5_async_in_service", 64'(in_service), 64'(0));
      chk("s5_async_pending", 64'(pending), 64'(0));
      model_reset();
      repeat (2) cycle();
      rst = 1'b1;
      repeat (10) cycle();
      chk("s5_no_load", 64'(load_cnt - lc), 64'(0));
      chk("s5_npush", 64'(obs_push.size()), 64'(1));

      // RTI while idle is ignored.
      bus.rti_done = 1'b1; cycle(); bus.rti_done = 1'b0;
      cycle();
      chk("rti_idle_svc", 64'(in_service), 64'(0));
      chk("rti_idle_stall", 64'(bus.fetch_stall), 64'(0));

      // Level-sensitive instance: a held request re-enters right after RTI.
      irq_l = 4'b0001;
      for (int i = 0; i < 40 && !in_service_l; i++) cycle();
      chk("lvl_svc", 64'(in_service_l), 64'(1));
      chk("lvl_pend", 64'(pending_l[0]), 64'(1));
      chk("lvl_id", 64'(active_id_l), 64'(0));
      bus_l.rti_done = 1'b1; cycle(); bus_l.rti_done = 1'b0;
      chk("lvl_exit", 64'(in_service_l), 64'(0));
      cycle();
      chk("lvl_reentry", 64'(bus_l.fetch_stall), 64'(1));
      irq_l = '0;

      // Random traffic against the model.
      for (int k = 0; k < 1500; k++) begin
         for (int b = 0; b < N; b++) irq[b] = ($urandom_range(0, 5) == 0);
         mask_we        = ($urandom_range(0, 15) == 0);
         mask_wdata     = N'($urandom);
         bus.pipe_empty = ($urandom_range(0, 3) != 0);
         bus.push_ready = ($urandom_range(0, 2) != 0);
         bus.rti_done   = ($urandom_range(0, 3) == 0);
         bus.pc_in      = $urandom;
         bus.flags_in   = 3'($urandom);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/intr_controller.md
Name: intr_controller

Overview:
Parametrised multi-source interrupt controller that replaces the single `interrupt_signal` path into the pipelined processor. It latches up to N_SRC interrupt requests and applies per-source masking and fixed priority. It sequences the entry: freeze fetch, wait for the pipeline to drain, push PC and flags through the memory-stage stack port, then load the vector PC. On RTI it re-arms.

Parameters:
N_SRC, 4, number of interrupt sources (1..8)
PC_W, 32, program counter width (multiple of 16)
DATA_W, 16, stack word width
FLAG_W, 3, flag register width
VEC_BASE, 0, address of vector 0; vector i is at VEC_BASE + i*(PC_W/DATA_W)
EDGE_MODE, 1, 1 = rising-edge sensitive sources, 0 = level sensitive

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
irq  in  N_SRC  raw interrupt requests, synchronous to clk
mask_we  in  1  write enable for mask register
mask_wdata  in  N_SRC  new mask value (1 = enabled)
pipe_empty  in  1  high when the execute and memory stages hold no valid instruction
pc_in  in  PC_W  PC to save (next un-executed instruction)
flags_in  in  FLAG_W  current flag register
push_valid  out  1  stack push request to the memory stage
push_data  out  DATA_W  word to push
push_ready  in  1  memory stage accepts the push this cycle
fetch_stall  out  1  freeze PC and insert NOP into decode
pc_load  out  1  one-cycle strobe: the PC takes pc_load_value
pc_load_value  out  PC_W  vector address
rti_done  in  1  one-cycle strobe from decode when RTI retires
in_service  out  1  handler active
active_id  out  $clog2(N_SRC) (min 1)  id of the serviced source
pending  out  N_SRC  latched pending bits

Behaviour:
- Reset (rst=0, async): state IDLE. pending=0, mask=all-ones. All outputs 0. active_id=0.
- Capture: EDGE_MODE=1 sets pending[i] on irq[i] 0->1, using a registered previous irq. EDGE_MODE=0 sets pending[i] when irq[i]=1. A pending bit clears only when its source is accepted.
- Capture is independent of the mask. A masked pending bit stays latched and fires when it is unmasked.
- mask_we updates mask at the clock edge. The new mask takes effect for selection in the following cycle.
- Select: eligible = pending & mask. The lowest index wins. Selection is evaluated only in IDLE.
- FSM states: IDLE -> DRAIN -> PUSH (one beat per word) -> LOAD -> SERVICE -> IDLE.
  - IDLE: if eligible!=0, latch id, pc_in and flags_in. Clear pending[id]. Go to DRAIN. fetch_stall=1 from the cycle after acceptance.
  - DRAIN: hold fetch_stall=1 until pipe_empty=1. If pipe_empty is already 1, DRAIN lasts exactly 1 cycle.
  - PUSH: push_valid=1. Words are pushed in this order: PC from MSW to LSW, then flags zero-extended to DATA_W. There are PC_W/DATA_W+1 words (3 by default).
  - A word advances only on push_valid&push_ready. push_data is stable while push_ready=0.
  - LOAD: pc_load=1 for 1 cycle. pc_load_value = VEC_BASE + id*(PC_W/DATA_W). fetch_stall drops in the same cycle.
  - SERVICE: in_service=1. Further interrupts do not nest; they stay pending. rti_done -> IDLE.
  - New selection is possible in the cycle after SERVICE exits.
- The same-cycle irq edge on an accepted source re-sets its pending bit (set wins over clear).
- rti_done outside SERVICE is ignored.
- A mask write during DRAIN/PUSH/LOAD does not abort the entry sequence.
- Reset mid-sequence returns to IDLE immediately. No partial push is completed.
- Minimum latency from eligible to pc_load, with pipe_empty=1 and push_ready=1: 1 (accept) + 1 (drain) + 3 (push) + 1 (load) = 6 cycles.

Decomposition:
- Shared package `intr_pkg`:
  - state enum `intr_state_t` {IDLE, DRAIN, PUSH, LOAD, SERVICE}
  - localparam `WORDS = PC_W/DATA_W`
  - function `vec_addr(id)`
- One natural sub-module: `prio_encoder` (N_SRC request vector -> valid + lowest-index id), reusable for future arbiters.

Test Plan:
- Single edge irq[2]; pipe_empty=1; push_ready=1; pc_in=0x0000_1234; flags=3'b101.
  -> push_data 0x0000, 0x1234, 0x0005 on consecutive cycles; pc_load_value=4 at cycle 6; active_id=2.
- irq[3] and irq[1] in the same cycle.
  -> id 1 serviced first; pending=4'b1000 during SERVICE; after rti_done, id 3 entry begins the next cycle.
- mask=4'b1110; pulse irq[0].
  -> no entry; pending[0]=1. Then write mask=4'b1111 -> entry starts 2 cycles after the write.
- pipe_empty held 0 for 4 cycles and push_ready toggling 1,0,1,0,1.
  -> fetch_stall high throughout; each word is held until accepted; exactly 3 pushes.
- Assert rst=0 during the second push beat.
  -> all outputs 0 asynchronously; pending=0; no pc_load follows.
- EDGE_MODE=0 with irq[0] held high through RTI.
  -> re-entry on id 0 right after SERVICE exits. Also check rti_done in IDLE causes no change.
